// File: rtl/rv_32_shift_issue_ctrl.sv
// Decodes RV32I shift instructions, issues one-cycle shifter operations and
// captures the registered result before the shifter floats its output.
module rv_32_shift_issue_ctrl #(
    parameter int ZERO_SHIFT_BYPASS = 1,
    parameter int CNT_W             = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [31:0]      instr,
    input  logic [31:0]      rs1_data,
    input  logic [31:0]      rs2_data,
    output logic             sh_enable,
    output logic             sh_logical,
    output logic             sh_direction,
    output logic [4:0]       sh_amount,
    output logic [31:0]      sh_data,
    input  logic [31:0]      sh_result,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [4:0]       wb_rd,
    output logic [31:0]      wb_data,
    output logic             illegal_instr,
    output logic [CNT_W-1:0] shift_count
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, WB} state_t;

    state_t           state_q, state_d;
    logic             instr_ready_q, instr_ready_d;
    logic             sh_enable_q, sh_enable_d;
    logic             sh_logical_q, sh_logical_d;
    logic             sh_direction_q, sh_direction_d;
    logic [4:0]       sh_amount_q, sh_amount_d;
    logic [31:0]      sh_data_q, sh_data_d;
    logic             wb_valid_q, wb_valid_d;
    logic [4:0]       wb_rd_q, wb_rd_d;
    logic [31:0]      wb_data_q, wb_data_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] shift_count_q, shift_count_d;

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic       is_rtype, is_itype, is_sll, is_srl, is_sra, legal;
    logic [4:0] amount;
    logic       accept;
    logic       unused_fields;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign funct7   = instr[31:25];
    assign is_rtype = (opcode == 7'b0110011);
    assign is_itype = (opcode == 7'b0010011);
    assign is_sll   = (funct3 == 3'b001) && (funct7 == 7'b0000000);
    assign is_srl   = (funct3 == 3'b101) && (funct7 == 7'b0000000);
    assign is_sra   = (funct3 == 3'b101) && (funct7 == 7'b0100000);
    // funct7 check also rejects immediate shifts with instr[25] set
    assign legal    = (is_rtype || is_itype) && (is_sll || is_srl || is_sra);
    assign amount   = is_rtype ? rs2_data[4:0] : instr[24:20];
    assign accept   = instr_valid && instr_ready_q && (state_q == IDLE);
    assign unused_fields = ^{rs2_data[31:5], instr[19:15]};

    always_comb begin
        state_d        = state_q;
        sh_logical_d   = sh_logical_q;
        sh_direction_d = sh_direction_q;
        sh_amount_d    = sh_amount_q;
        sh_data_d      = sh_data_q;
        wb_valid_d     = wb_valid_q;
        wb_rd_d        = wb_rd_q;
        wb_data_d      = wb_data_q;
        shift_count_d  = shift_count_q;
        illegal_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!legal) begin
                        illegal_d = 1'b1;
                    end else begin
                        wb_rd_d = instr[11:7];
                        if ((amount == 5'd0) && (ZERO_SHIFT_BYPASS != 0)) begin
                            wb_data_d  = rs1_data;
                            wb_valid_d = 1'b1;
                            state_d    = WB;
                        end else begin
                            sh_data_d      = rs1_data;
                            sh_amount_d    = amount;
                            sh_direction_d = !is_sll;
                            sh_logical_d   = !is_sra;
                            state_d        = ISSUE;
                        end
                    end
                end
            end
            ISSUE: state_d = CAPTURE;
            // Sample here: the shifter drives Z after the following edge
            CAPTURE: begin
                wb_data_d  = sh_result;
                wb_valid_d = 1'b1;
                state_d    = WB;
            end
            WB: begin
                if (wb_ready) begin
                    wb_valid_d = 1'b0;
                    state_d    = IDLE;
                    if (shift_count_q != {CNT_W{1'b1}})
                        shift_count_d = shift_count_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        sh_enable_d   = (state_d == ISSUE);
        instr_ready_d = (state_d == IDLE) && !illegal_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            instr_ready_q  <= 1'b0;
            sh_enable_q    <= 1'b0;
            sh_logical_q   <= 1'b0;
            sh_direction_q <= 1'b0;
            sh_amount_q    <= 5'd0;
            sh_data_q      <= 32'd0;
            wb_valid_q     <= 1'b0;
            wb_rd_q        <= 5'd0;
            wb_data_q      <= 32'd0;
            illegal_q      <= 1'b0;
            shift_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            instr_ready_q  <= instr_ready_d;
            sh_enable_q    <= sh_enable_d;
            sh_logical_q   <= sh_logical_d;
            sh_direction_q <= sh_direction_d;
            sh_amount_q    <= sh_amount_d;
            sh_data_q      <= sh_data_d;
            wb_valid_q     <= wb_valid_d;
            wb_rd_q        <= wb_rd_d;
            wb_data_q      <= wb_data_d;
            illegal_q      <= illegal_d;
            shift_count_q  <= shift_count_d;
        end
    end

    assign instr_ready   = instr_ready_q;
    assign sh_enable     = sh_enable_q;
    assign sh_logical    = sh_logical_q;
    assign sh_direction  = sh_direction_q;
    assign sh_amount     = sh_amount_q;
    assign sh_data       = sh_data_q;
    assign wb_valid      = wb_valid_q;
    assign wb_rd         = wb_rd_q;
    assign wb_data       = wb_data_q;
    assign illegal_instr = illegal_q;
    assign shift_count   = shift_count_q;

endmodule

// File: tb/tb_rv_32_shift_issue_ctrl.sv
// Directed bench for rv_32_shift_issue_ctrl with a registered, Z-when-idle shifter model.
module tb_rv_32_shift_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr = 32'd0;
    logic [31:0] rs1_data = 32'd0;
    logic [31:0] rs2_data = 32'd0;
    logic        sh_enable, sh_logical, sh_direction;
    logic [4:0]  sh_amount;
    logic [31:0] sh_data;
    logic [31:0] sh_result;
    logic        wb_valid;
    logic        wb_ready = 1'b1;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        illegal_instr;
    logic [15:0] shift_count;

    int passed = 0;
    int total  = 0;
    bit sh_seen = 1'b0;

    rv_32_shift_issue_ctrl #(.ZERO_SHIFT_BYPASS(1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .sh_enable(sh_enable), .sh_logical(sh_logical), .sh_direction(sh_direction),
        .sh_amount(sh_amount), .sh_data(sh_data), .sh_result(sh_result),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .illegal_instr(illegal_instr), .shift_count(shift_count)
    );

    always #5 clk = ~clk;

    // Shifter model: latches when enabled, floats when a clock edge sees it disabled
    always @(posedge clk) begin
        if (sh_enable) begin
            sh_seen <= 1'b1;
            if (!sh_direction)    sh_result <= sh_data << sh_amount;
            else if (sh_logical)  sh_result <= sh_data >> sh_amount;
            else                  sh_result <= $unsigned($signed(sh_data) >>> sh_amount);
        end else begin
            sh_result <= 'z;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Offer one instruction and return at the negedge following the acceptance edge
    task automatic send(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        @(negedge clk);
        instr = i; rs1_data = a; rs2_data = b; instr_valid = 1'b1;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", {31'd0, instr_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    initial begin
        // Reset values
        #12;
        chk("rst_ready", {31'd0, instr_ready}, 32'd0);
        chk("rst_outs", {sh_enable, sh_logical, sh_direction, wb_valid, illegal_instr, sh_amount, wb_rd},
            32'd0);
        chk("rst_cnt", {16'd0, shift_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", {31'd0, instr_ready}, 32'd1);

        // SRAI x5,x6,4
        send(32'h40435293, 32'h800000F0, 32'd0);
        chk("srai_en", {31'd0, sh_enable}, 32'd1);
        chk("srai_ctl", {27'd0, sh_direction, sh_logical, sh_amount[2:0]}, {27'd0, 1'b1, 1'b0, 3'd4});
        chk("srai_amt", {27'd0, sh_amount}, 32'd4);
        chk("srai_ready_busy", {31'd0, instr_ready}, 32'd0);
        @(negedge clk);
        chk("srai_capture", {30'd0, sh_enable, wb_valid}, 32'd0);
        @(negedge clk);
        chk("srai_wbv", {31'd0, wb_valid}, 32'd1);
        chk("srai_rd", {27'd0, wb_rd}, 32'd5);
        chk("srai_data", wb_data, 32'hF800000F);
        @(negedge clk);
        chk("srai_cnt", {16'd0, shift_count}, 32'd1);
        chk("srai_wbv_drop", {31'd0, wb_valid}, 32'd0);

        // SLL x1,x2,x3 with rs2 upper bits set
        send(32'h003110B3, 32'h00000001, 32'h00000024);
        chk("sll_amt", {27'd0, sh_amount}, 32'd4);
        chk("sll_dir", {30'd0, sh_direction, sh_logical}, 32'b01);
        chk("sll_data_in", sh_data, 32'h00000001);
        @(negedge clk);
        @(negedge clk);
        chk("sll_data", wb_data, 32'h00000010);
        chk("sll_rd", {27'd0, wb_rd}, 32'd1);

        // SRL x1,x2,x3 by 31
        send(32'h003150B3, 32'hFFFFFFFF, 32'd31);
        chk("srl_dir", {30'd0, sh_direction, sh_logical}, 32'b11);
        chk("srl_cnt_before", {16'd0, shift_count}, 32'd2);
        @(negedge clk);
        @(negedge clk);
        chk("srl_data", wb_data, 32'h00000001);
        @(negedge clk);
        chk("srl_cnt_after", {16'd0, shift_count}, 32'd3);

        // SRLI x7,x8,0 takes the bypass
        sh_seen = 1'b0;
        send(32'h00045393, 32'hDEADBEEF, 32'd0);
        chk("byp_wbv", {31'd0, wb_valid}, 32'd1);
        chk("byp_data", wb_data, 32'hDEADBEEF);
        chk("byp_rd", {27'd0, wb_rd}, 32'd7);
        @(negedge clk);
        chk("byp_no_shift", {31'd0, sh_seen}, 32'd0);
        chk("byp_cnt", {16'd0, shift_count}, 32'd4);

        // Illegal SLLI with instr[25] set
        sh_seen = 1'b0;
        send(32'h02009093, 32'h12345678, 32'd0);
        chk("ill_pulse", {31'd0, illegal_instr}, 32'd1);
        chk("ill_ready_low", {31'd0, instr_ready}, 32'd0);
        chk("ill_no_wb", {30'd0, sh_enable, wb_valid}, 32'd0);
        @(negedge clk);
        chk("ill_pulse_end", {31'd0, illegal_instr}, 32'd0);
        chk("ill_ready_back", {31'd0, instr_ready}, 32'd1);
        chk("ill_quiet", {30'd0, sh_seen, wb_valid}, 32'd0);
        chk("ill_cnt", {16'd0, shift_count}, 32'd4);

        // Writeback held off for 5 cycles
        wb_ready = 1'b0;
        send(32'h003110B3, 32'h00000003, 32'h00000008);
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("hold_wbv", {31'd0, wb_valid}, 32'd1);
            chk("hold_rd", {27'd0, wb_rd}, 32'd1);
            chk("hold_data", wb_data, 32'h00000300);
            @(negedge clk);
        end
        wb_ready = 1'b1;
        @(negedge clk);
        chk("hold_release", {31'd0, wb_valid}, 32'd0);
        chk("hold_cnt", {16'd0, shift_count}, 32'd5);

        // Reset during ISSUE
        send(32'h003150B3, 32'hFFFFFFFF, 32'd4);
        chk("mid_en", {31'd0, sh_enable}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_en", {31'd0, sh_enable}, 32'd0);
        chk("mid_rst_outs", {instr_ready, wb_valid, illegal_instr, sh_direction, sh_logical, sh_amount, wb_rd},
            32'd0);
        chk("mid_rst_data", sh_data | wb_data, 32'd0);
        chk("mid_rst_cnt", {16'd0, shift_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rel_ready", {31'd0, instr_ready}, 32'd0);
        @(negedge clk);
        chk("mid_ready_up", {31'd0, instr_ready}, 32'd1);
        chk("mid_no_wb", {30'd0, wb_valid, sh_enable}, 32'd0);
        @(negedge clk);
        chk("mid_still_idle", {30'd0, wb_valid, sh_enable}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
